// File: rtl/avalon_addr_demux_pkg.sv
// Purpose: shared Avalon-MM interconnect widths, terminator constants and demux state type.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package avalon_addr_demux_pkg;

  localparam int AV_ADDR_W  = 30;
  localparam int AV_DATA_W  = 32;
  localparam int AV_BURST_W = 8;
  localparam int AV_BE_W    = 4;

  // Read data returned for accesses that hit no mapped target.
  localparam logic [AV_DATA_W-1:0] TERM_READ_DATA = 32'h0000_0000;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } demux_state_t;

  // A burst count of zero is an alias for a single beat.
  function automatic logic [AV_BURST_W-1:0] eff_burst(input logic [AV_BURST_W-1:0] bc);
    return (bc == '0) ? AV_BURST_W'(1) : bc;
  endfunction

endpackage

// File: rtl/avalon_addr_demux_decoder.sv
// Purpose: first-match word-address decode against per-target base/mask pairs.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the address in the same cycle.
//
// Ports:
//   addr - initiator word address
//   sel  - index of the lowest matching target, or NUM_OUTPUTS when nothing matches
module avalon_addr_decoder
  import avalon_addr_demux_pkg::*;
#(
  parameter int                             NUM_OUTPUTS = 2,
  parameter int                             SEL_W       = $clog2(NUM_OUTPUTS + 1),
  parameter logic [AV_ADDR_W*NUM_OUTPUTS-1:0] BASE_ADDRS  = '0,
  parameter logic [AV_ADDR_W*NUM_OUTPUTS-1:0] ADDR_MASKS  = '0
) (
  input  logic [AV_ADDR_W-1:0] addr,
  output logic [SEL_W-1:0]     sel
);

  // Scan from the highest index down so that the lowest matching index
  // is the last one written and therefore wins.
  always_comb begin
    sel = SEL_W'(NUM_OUTPUTS);
    for (int k = NUM_OUTPUTS - 1; k >= 0; k--) begin
      if ((addr & ADDR_MASKS[AV_ADDR_W*k +: AV_ADDR_W]) == BASE_ADDRS[AV_ADDR_W*k +: AV_ADDR_W]) begin
        sel = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/avalon_addr_demux.sv
// Purpose: fan one Avalon-MM initiator out to NUM_OUTPUTS targets by address, burst-locked routing.
// Latency: zero-cycle combinational routing; lock/counter/decode error update on the next i_Clk edge.
// Backpressure: selected target's waitrequest passes straight back; unmapped beats never stall.
//
// Ports:
//   i_Clk, i_Rst_n                      - clock, async active-low reset
//   i_AVIn_*  / o_AVIn_*                - initiator-facing Avalon-MM slave port
//   o_AVOut_* / i_AVOut_*               - NUM_OUTPUTS packed target-facing master ports
//   o_DecodeErr                         - one-cycle pulse after each completed unmapped beat
module avalon_addr_demux
  import avalon_addr_demux_pkg::*;
#(
  parameter int                             NUM_OUTPUTS = 2,
  parameter logic [AV_ADDR_W*NUM_OUTPUTS-1:0] BASE_ADDRS  = '0,
  parameter logic [AV_ADDR_W*NUM_OUTPUTS-1:0] ADDR_MASKS  = '0
) (
  input  logic                              i_Clk,
  input  logic                              i_Rst_n,
  input  logic [AV_ADDR_W-1:0]              i_AVIn_Addr,
  input  logic [AV_BE_W-1:0]                i_AVIn_ByteEn,
  input  logic                              i_AVIn_Read,
  input  logic                              i_AVIn_Write,
  input  logic [AV_DATA_W-1:0]              i_AVIn_WriteData,
  input  logic [AV_BURST_W-1:0]             i_AVIn_BurstCount,
  output logic [AV_DATA_W-1:0]              o_AVIn_ReadData,
  output logic                              o_AVIn_WaitRequest,
  output logic [AV_ADDR_W*NUM_OUTPUTS-1:0]  o_AVOut_Addr,
  output logic [AV_BE_W*NUM_OUTPUTS-1:0]    o_AVOut_ByteEn,
  output logic [AV_DATA_W*NUM_OUTPUTS-1:0]  o_AVOut_WriteData,
  output logic [AV_BURST_W*NUM_OUTPUTS-1:0] o_AVOut_BurstCount,
  output logic [NUM_OUTPUTS-1:0]            o_AVOut_Read,
  output logic [NUM_OUTPUTS-1:0]            o_AVOut_Write,
  input  logic [AV_DATA_W*NUM_OUTPUTS-1:0]  i_AVOut_ReadData,
  input  logic [NUM_OUTPUTS-1:0]            i_AVOut_WaitRequest,
  output logic                              o_DecodeErr
);

  localparam int SEL_W = $clog2(NUM_OUTPUTS + 1);

  demux_state_t          state, state_nxt;
  logic [SEL_W-1:0]      dec_sel;
  logic [SEL_W-1:0]      sel;
  logic [SEL_W-1:0]      sel_locked;
  logic [AV_BURST_W-1:0] beats_left;
  logic [AV_BURST_W-1:0] burst_len;
  logic                  term;
  logic                  wait_sel;
  logic                  wait_req;
  logic                  beat_done;
  logic                  decode_err;

  avalon_addr_decoder #(
    .NUM_OUTPUTS (NUM_OUTPUTS),
    .SEL_W       (SEL_W),
    .BASE_ADDRS  (BASE_ADDRS),
    .ADDR_MASKS  (ADDR_MASKS)
  ) u_decoder (
    .addr (i_AVIn_Addr),
    .sel  (dec_sel)
  );

  // Inside a burst the address is ignored for routing; the first-beat target sticks.
  assign sel       = (state == BURST) ? sel_locked : dec_sel;
  assign term      = (sel == SEL_W'(NUM_OUTPUTS));
  assign burst_len = eff_burst(i_AVIn_BurstCount);

  // Selected-target response; the defaults are the terminator's response.
  always_comb begin
    o_AVIn_ReadData = TERM_READ_DATA;
    wait_sel        = 1'b0;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      if (sel == SEL_W'(k)) begin
        o_AVIn_ReadData = i_AVOut_ReadData[AV_DATA_W*k +: AV_DATA_W];
        wait_sel        = i_AVOut_WaitRequest[k];
      end
    end
  end

  // Holding the initiator off during reset keeps it from counting a beat nobody saw.
  assign wait_req           = ~i_Rst_n | wait_sel;
  assign o_AVIn_WaitRequest = wait_req;
  assign beat_done          = (i_AVIn_Read | i_AVIn_Write) & ~wait_req;

  assign o_AVOut_Addr       = {NUM_OUTPUTS{i_AVIn_Addr}};
  assign o_AVOut_ByteEn     = {NUM_OUTPUTS{i_AVIn_ByteEn}};
  assign o_AVOut_WriteData  = {NUM_OUTPUTS{i_AVIn_WriteData}};
  assign o_AVOut_BurstCount = {NUM_OUTPUTS{i_AVIn_BurstCount}};

  // FSM: state register
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (beat_done && (burst_len > AV_BURST_W'(1))) state_nxt = BURST;
      BURST: if (beat_done && (beats_left == AV_BURST_W'(1))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs - only the routed target sees strobes, and none while in reset.
  always_comb begin
    o_AVOut_Read  = '0;
    o_AVOut_Write = '0;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      if (i_Rst_n && (sel == SEL_W'(k))) begin
        o_AVOut_Read[k]  = i_AVIn_Read;
        o_AVOut_Write[k] = i_AVIn_Write;
      end
    end
  end

  // Burst lock and beat counter; the error flag registers terminator completions.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sel_locked <= '0;
      beats_left <= '0;
      decode_err <= 1'b0;
    end else begin
      decode_err <= beat_done & term;
      if (beat_done) begin
        if (state == IDLE) begin
          if (burst_len > AV_BURST_W'(1)) begin
            sel_locked <= sel;
            beats_left <= burst_len - AV_BURST_W'(1);
          end
        end else begin
          beats_left <= beats_left - AV_BURST_W'(1);
        end
      end
    end
  end

  assign o_DecodeErr = decode_err;

endmodule
